// File: rtl/x_mem_player_2048x2.sv
// Sequential sample reader for the 2048x2 sample memory: walks addresses 0..last,
// capturing one sample every div+1 cycles, in one-shot or looping mode.
module x_mem_player_2048x2 #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 2,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_loop,
  input  logic [ADDR_W-1:0] i_last,
  input  logic [DIV_W-1:0]  i_div,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_sample,
  output logic              o_sample_vld,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                loop_q, loop_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                vld_q, vld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // State and output registers
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      last_q    <= '0;
      div_cnt_q <= '0;
      div_q     <= '0;
      loop_q    <= 1'b0;
      sample_q  <= '0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      div_cnt_q <= div_cnt_d;
      div_q     <= div_d;
      loop_q    <= loop_d;
      sample_q  <= sample_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state: strobes are single-cycle, wrap at last is explicit
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    last_d    = last_q;
    div_cnt_d = div_cnt_q;
    div_d     = div_q;
    loop_d    = loop_q;
    sample_d  = sample_q;
    vld_d     = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (i_start && !i_stop) begin
          last_d    = i_last;
          div_d     = i_div;
          loop_d    = i_loop;
          div_cnt_d = '0;
          state_d   = S_PLAY;
        end
      end
      S_PLAY: begin
        if (i_stop) begin
          addr_d  = '0;
          state_d = S_IDLE;
        end else if (div_cnt_q != div_q) begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end else begin
          sample_d  = i_mem_rdata;
          vld_d     = 1'b1;
          div_cnt_d = '0;
          if (addr_q != last_q) begin
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            addr_d = '0;
            if (!loop_q) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      default: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_PLAY);
  end

  assign o_mem_addr   = addr_q;
  assign o_sample     = sample_q;
  assign o_sample_vld = vld_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: doc/x_mem_player_2048x2.md
# x_mem_player_2048x2

Sequential sample reader for the 2048x2 sample memory. Once started, it walks the memory address from 0 up to a programmed last address. It captures one 2-bit sample every `i_div+1` clock cycles and presents each sample to the downstream DAC/modulator with a single-cycle valid strobe. Playback is either one-shot or looping. This block is the read-side counterpart of the memory's write port and is the only driver of its address during playback.

## Interface
Parameters:
- `ADDR_W`, default 11: memory address width (depth 2^ADDR_W = 2048).
- `DATA_W`, default 2: sample width.
- `DIV_W`, default 16: width of the sample-rate divider.

Ports:
- `i_clk`, input, 1: clock.
- `i_nrst`, input, 1: reset; asynchronous, active-low.
- `i_start`, input, 1: start playback (sampled in IDLE only).
- `i_stop`, input, 1: abort playback.
- `i_loop`, input, 1: 1 = wrap to address 0 after the last address; latched at start.
- `i_last`, input, ADDR_W: last address to play, inclusive; latched at start.
- `i_div`, input, DIV_W: sample period minus 1, in cycles; latched at start.
- `o_mem_addr`, output, ADDR_W: address to memory (memory read is combinational).
- `i_mem_rdata`, input, DATA_W: memory read data for `o_mem_addr`, valid the same cycle.
- `o_sample`, output, DATA_W: last captured sample; held between strobes.
- `o_sample_vld`, output, 1: one-cycle pulse when `o_sample` updates.
- `o_busy`, output, 1: high while in PLAY.
- `o_done`, output, 1: one-cycle pulse on natural end of a one-shot playback.

## Operation
- FSM states: IDLE, PLAY. Registered state: `addr_q`, `div_cnt_q`, `last_q`, `div_q`, `loop_q`, plus all outputs.
- All outputs are registered.
- IDLE behaviour:
  - `addr_q` is 0.
  - If `i_start=1` and `i_stop=0`: latch `i_last`, `i_div`, `i_loop`; set `addr_q=0` and `div_cnt_q=0`; go to PLAY.
  - If `i_start=1` and `i_stop=1`: stay in IDLE.
- PLAY, when `i_stop=1`: go to IDLE and set `addr_q=0`. No sample is captured and no `o_done` is pulsed that cycle. `o_sample` keeps its value.
- PLAY, otherwise, when `div_cnt_q != div_q`: `div_cnt_q++`.
- PLAY, otherwise, when `div_cnt_q == div_q`:
  - Set `o_sample <= i_mem_rdata`, `o_sample_vld <= 1`, `div_cnt_q <= 0`.
  - If `addr_q != last_q`: `addr_q++`.
  - If `addr_q == last_q` and `loop_q=1`: `addr_q <= 0` and stay in PLAY.
  - If `addr_q == last_q` and `loop_q=0`: `addr_q <= 0`, `o_done <= 1`, go to IDLE.
- `i_start` in PLAY is ignored. Changes to `i_last`, `i_div`, `i_loop` during PLAY have no effect.
- `o_mem_addr = addr_q`.
- The address counter is ADDR_W bits. With `i_last=2047` it never relies on natural overflow; wrap is explicit.
- Arithmetic: `div_cnt_q` is DIV_W bits and is compared against `div_q` by equality only.
- `o_busy = (state == PLAY)`.

## Timing
- Reset: state IDLE; `o_mem_addr`, `o_sample`, `o_sample_vld`, `o_busy`, `o_done` and all internal registers are 0.
- Reset asserted mid-playback returns the block to IDLE immediately. No `o_done` is generated.
- Start edge at cycle N: at N+1, `o_busy=1` and `o_mem_addr=0`.
- The first `o_sample_vld` is high in cycle N+2+`div`, carrying `mem[0]`.
- Samples then follow every `div+1` cycles: `mem[1]`, `mem[2]`, …
- With `div=0`, one sample per cycle and `o_sample_vld` is continuously high.
- One-shot: the final `o_sample_vld` and `o_done` are high in the same cycle. `o_busy` is 0 in that same cycle.
- One-shot total: `(last+1)*(div+1)` strobes-period cycles after entering PLAY.
- `i_last=0`: exactly one sample (`mem[0]`) per pass. In loop mode with `div=0`, `mem[0]` repeats every cycle.
- A new start is accepted in the cycle after `o_done`, since the block is already in IDLE.
- Loop wrap from `last` to 0 inserts no extra cycles: the sample period stays `div+1` across the wrap.

## Test plan
- **Reset values:** assert `i_nrst=0` mid-PLAY → all outputs 0 next sample point. After release, block idles with `o_mem_addr=0`.
- **One-shot:** memory preloaded `mem[k]=k%4`; `last=5`, `div=2`, `loop=0`.
  - Expect 6 strobes, 3 cycles apart, with values 0,1,2,3,0,1.
  - `o_done` coincides with the 6th strobe; `o_busy` falls the same cycle.
- **Loop, full depth:** `last=2047`, `div=0`, `loop=1`.
  - Expect `o_sample_vld` continuously high and addresses 0..2047,0,1.
  - Samples match the memory with no gap at the wrap; `o_done` is never pulsed.
- **Stop:** `i_stop` mid-PLAY, in a strobe cycle → no strobe that cycle, no `o_done`, `o_busy=0` next cycle, `o_sample` unchanged.
  - `i_start` and `i_stop` together in IDLE → stays IDLE.
- **Parameter latching and start-ignore:**
  - Change `i_div` from 3 to 0 during PLAY → the period stays 4 cycles.
  - `i_start` pulses in PLAY are ignored (address sequence unbroken).
- **Edge cases:**
  - `last=0`, `div=0`, one-shot → exactly one strobe with `mem[0]`, and `o_done` in that cycle.
  - A restart in the following cycle → the first strobe arrives 2 cycles later.
